// File: rtl/event_timestamper_mc_if.sv
// rtl/event_timestamper_mc_if.sv - start/end request, record output and monitor bundle
// Purpose: groups every non-clock signal of event_timestamper_mc.
// Ports (slave = timestamper side):
//   start_valid/start_ready/start_id : open an event ID
//   end_valid/end_ready/end_id       : close an event ID
//   out_valid/out_ready/out_*        : record FIFO head {id, start_ts, end_ts, delta, timeout}
//   inflight/out_count               : open-ID count and FIFO occupancy
interface event_timestamper_mc_if #(
    parameter int ID_W      = 4,
    parameter int TS_W      = 64,
    parameter int OUT_DEPTH = 4
);
    logic                         start_valid;
    logic                         start_ready;
    logic [ID_W-1:0]              start_id;
    logic                         end_valid;
    logic                         end_ready;
    logic [ID_W-1:0]              end_id;
    logic                         out_valid;
    logic                         out_ready;
    logic [ID_W-1:0]              out_id;
    logic [TS_W-1:0]              out_start_ts;
    logic [TS_W-1:0]              out_end_ts;
    logic [TS_W-1:0]              out_ts;
    logic                         out_timeout;
    logic [ID_W:0]                inflight;
    logic [$clog2(OUT_DEPTH):0]   out_count;

    modport slave (
        input  start_valid, start_id, end_valid, end_id, out_ready,
        output start_ready, end_ready, out_valid, out_id, out_start_ts,
               out_end_ts, out_ts, out_timeout, inflight, out_count
    );

    modport master (
        output start_valid, start_id, end_valid, end_id, out_ready,
        input  start_ready, end_ready, out_valid, out_id, out_start_ts,
               out_end_ts, out_ts, out_timeout, inflight, out_count
    );
endinterface

// File: rtl/event_timestamper_mc.sv
// rtl/event_timestamper_mc.sv - multi-ID event timestamper with record FIFO and timeout sweeper
// Purpose: tracks up to 2**ID_W open event IDs, emits {id, start, end, delta, timeout}
//          records through an OUT_DEPTH-entry first-word-fall-through FIFO.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : event_timestamper_mc_if.slave (start/end requests, record output, monitors)
module event_timestamper_mc #(
    parameter int ID_W      = 4,
    parameter int TS_W      = 64,
    parameter int OUT_DEPTH = 4,
    parameter int TIMEOUT   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    event_timestamper_mc_if.slave   bus
);
    localparam int DEPTH = 1 << ID_W;
    localparam int PW    = $clog2(OUT_DEPTH);
    localparam int CW    = PW + 1;

    logic [TS_W-1:0]  r_cnt;
    logic [DEPTH-1:0] r_vld;
    logic [TS_W-1:0]  r_sts [DEPTH];
    logic [ID_W:0]    r_inflight;

    logic [ID_W-1:0]  r_mem_id  [OUT_DEPTH];
    logic [TS_W-1:0]  r_mem_sts [OUT_DEPTH];
    logic [TS_W-1:0]  r_mem_ets [OUT_DEPTH];
    logic             r_mem_to  [OUT_DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_pop;
    logic             w_room;
    logic             w_end_ready;
    logic             w_end_fire;
    logic             w_start_ready;
    logic             w_start_fire;
    logic             w_retire;
    logic [ID_W-1:0]  w_sweep_id;
    logic             w_push;
    logic [ID_W-1:0]  w_push_id;

    assign w_pop         = (r_count != '0) && bus.out_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign w_room        = (r_count < CW'(OUT_DEPTH)) || w_pop;
    assign w_end_ready   = r_vld[bus.end_id] && w_room;
    assign w_end_fire    = bus.end_valid && w_end_ready;
    assign w_start_ready = !r_vld[bus.start_id] || (w_end_fire && (bus.end_id == bus.start_id));
    assign w_start_fire  = bus.start_valid && w_start_ready;

    // End requests own the single FIFO write port; the sweeper only fills idle slots.
    assign w_push    = w_end_fire || w_retire;
    assign w_push_id = w_end_fire ? bus.end_id : w_sweep_id;

    generate
        if (TIMEOUT > 0) begin : g_sweep
            logic [ID_W-1:0] r_sweep_ptr;
            logic [TS_W-1:0] w_age;
            logic            w_stale;

            assign w_age      = r_cnt - r_sts[r_sweep_ptr];
            assign w_stale    = r_vld[r_sweep_ptr] && (w_age >= TS_W'(TIMEOUT));
            assign w_retire   = w_stale && !w_end_fire && w_room;
            assign w_sweep_id = r_sweep_ptr;

            // Hold on a stale ID that could not be retired so it is not skipped.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sweep_ptr <= '0;
                end else if (!(w_stale && !w_retire)) begin
                    r_sweep_ptr <= r_sweep_ptr + ID_W'(1);
                end
            end
        end else begin : g_nosweep
            assign w_retire   = 1'b0;
            assign w_sweep_id = '0;
        end
    endgenerate

    // Start timestamps need no reset: they are only read while the valid bit is set.
    always_ff @(posedge clk) begin
        if (w_start_fire) begin
            r_sts[bus.start_id] <= r_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_vld      <= '0;
            r_inflight <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                r_mem_id[i]  <= '0;
                r_mem_sts[i] <= '0;
                r_mem_ets[i] <= '0;
                r_mem_to[i]  <= 1'b0;
            end
        end else begin
            r_cnt <= r_cnt + TS_W'(1);

            // Start is applied last so a same-cycle close+reopen leaves the ID open.
            if (w_end_fire) r_vld[bus.end_id] <= 1'b0;
            if (w_retire)   r_vld[w_sweep_id] <= 1'b0;
            if (w_start_fire) r_vld[bus.start_id] <= 1'b1;

            if (w_push) begin
                r_mem_id[r_wr_ptr]  <= w_push_id;
                r_mem_sts[r_wr_ptr] <= r_sts[w_push_id];
                r_mem_ets[r_wr_ptr] <= r_cnt;
                r_mem_to[r_wr_ptr]  <= !w_end_fire;
                r_wr_ptr            <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count    <= r_count + CW'(w_push) - CW'(w_pop);
            r_inflight <= r_inflight + (ID_W+1)'(w_start_fire)
                                     - (ID_W+1)'(w_end_fire)
                                     - (ID_W+1)'(w_retire);
        end
    end

    assign bus.start_ready  = w_start_ready;
    assign bus.end_ready    = w_end_ready;
    assign bus.out_valid    = (r_count != '0);
    assign bus.out_id       = r_mem_id[r_rd_ptr];
    assign bus.out_start_ts = r_mem_sts[r_rd_ptr];
    assign bus.out_end_ts   = r_mem_ets[r_rd_ptr];
    // Delta is derived at the head; modulo subtraction handles counter wrap.
    assign bus.out_ts       = r_mem_ets[r_rd_ptr] - r_mem_sts[r_rd_ptr];
    assign bus.out_timeout  = r_mem_to[r_rd_ptr];
    assign bus.inflight     = r_inflight;
    assign bus.out_count    = r_count;
endmodule

// File: tb/tb_event_timestamper_mc.sv
// tb/tb_event_timestamper_mc.sv - randomized and directed bench for event_timestamper_mc
module tb_event_timestamper_mc;
    localparam int ID_W  = 4;
    localparam int TS_W  = 8;
    localparam int OD    = 4;
    localparam int TO    = 32;
    localparam int DEPTH = 16;
    localparam int MOD   = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    event_timestamper_mc_if #(.ID_W(ID_W), .TS_W(TS_W), .OUT_DEPTH(OD)) bus ();

    event_timestamper_mc #(.ID_W(ID_W), .TS_W(TS_W), .OUT_DEPTH(OD), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        int id;
        int s;
        int e;
        bit to;
    } rec_t;

    bit   m_vld [DEPTH];
    int   m_sts [DEPTH];
    int   m_cnt;
    int   m_sp;
    rec_t m_q [$];

    function automatic int age(input int id);
        return (m_cnt - m_sts[id] + MOD) % MOD;
    endfunction

    task automatic check_outputs();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += m_vld[i];
        chk("inflight", bus.inflight, n);
        chk("out_count", bus.out_count, m_q.size());
        chk("out_valid", bus.out_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            chk("out_id", bus.out_id, m_q[0].id);
            chk("out_start_ts", bus.out_start_ts, m_q[0].s);
            chk("out_end_ts", bus.out_end_ts, m_q[0].e);
            chk("out_ts", bus.out_ts, (m_q[0].e - m_q[0].s + MOD) % MOD);
            chk("out_timeout", bus.out_timeout, m_q[0].to);
        end
    endtask

    // One clock: drive inputs, check readies against the model, advance model across the edge.
    task automatic drive(input bit sv, input int sid, input bit ev, input int eid, input bit ordy);
        bit room, er, ef, sr, sf, stale, ret;
        bus.start_valid = sv;
        bus.start_id    = ID_W'(sid);
        bus.end_valid   = ev;
        bus.end_id      = ID_W'(eid);
        bus.out_ready   = ordy;
        #1;
        room  = (m_q.size() < OD) || (m_q.size() > 0 && ordy);
        er    = m_vld[eid] && room;
        ef    = ev && er;
        sr    = !m_vld[sid] || (ef && eid == sid);
        sf    = sv && sr;
        stale = m_vld[m_sp] && age(m_sp) >= TO;
        ret   = stale && !ef && room;
        chk("end_ready", bus.end_ready, er);
        chk("start_ready", bus.start_ready, sr);
        @(posedge clk);
        if (m_q.size() > 0 && ordy) void'(m_q.pop_front());
        if (ef)       m_q.push_back('{eid, m_sts[eid], m_cnt, 1'b0});
        else if (ret) m_q.push_back('{m_sp, m_sts[m_sp], m_cnt, 1'b1});
        if (ef)  m_vld[eid] = 1'b0;
        if (ret) m_vld[m_sp] = 1'b0;
        if (sf) begin
            m_vld[sid] = 1'b1;
            m_sts[sid] = m_cnt;
        end
        if (!(stale && !ret)) m_sp = (m_sp + 1) % DEPTH;
        m_cnt = (m_cnt + 1) % MOD;
        #1;
        check_outputs();
    endtask

    task automatic idle(input bit ordy);
        drive(1'b0, 0, 1'b0, 0, ordy);
    endtask

    task automatic idle_until_cnt(input int c);
        for (int k = 0; k < MOD + 2 && m_cnt != c; k++) idle(1'b1);
        chk("reach_cnt", m_cnt, c);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.start_valid = 1'b0;
        bus.end_valid   = 1'b0;
        bus.out_ready   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
        m_q.delete();
        m_cnt = 0;
        m_sp  = 0;
        check_outputs();
        chk("rst_out_id", bus.out_id, 0);
        chk("rst_out_start_ts", bus.out_start_ts, 0);
        chk("rst_out_end_ts", bus.out_end_ts, 0);
        chk("rst_out_timeout", bus.out_timeout, 0);
    endtask

    initial begin
        bit seen;
        bus.start_valid = 1'b0;
        bus.start_id    = '0;
        bus.end_valid   = 1'b0;
        bus.end_id      = '0;
        bus.out_ready   = 1'b0;
        do_reset();

        // Basic open/close.
        idle_until_cnt(10);
        drive(1'b1, 3, 1'b0, 0, 1'b1);
        chk("basic_inflight_open", bus.inflight, 1);
        idle_until_cnt(25);
        drive(1'b0, 0, 1'b1, 3, 1'b1);
        chk("basic_id", bus.out_id, 3);
        chk("basic_start", bus.out_start_ts, 10);
        chk("basic_end", bus.out_end_ts, 25);
        chk("basic_ts", bus.out_ts, 15);
        chk("basic_to", bus.out_timeout, 0);
        chk("basic_inflight_closed", bus.inflight, 0);

        // Same-cycle close and reopen of id 5.
        idle_until_cnt(30);
        drive(1'b1, 5, 1'b0, 0, 1'b1);
        idle_until_cnt(50);
        drive(1'b1, 5, 1'b1, 5, 1'b1);
        chk("reopen_start", bus.out_start_ts, 30);
        chk("reopen_end", bus.out_end_ts, 50);
        chk("reopen_ts", bus.out_ts, 20);
        chk("reopen_inflight", bus.inflight, 1);

        // Id 5 left open must be retired by the sweeper.
        seen = 1'b0;
        for (int k = 0; k < 80 && !seen; k++) begin
            idle(1'b1);
            if (bus.out_valid && bus.out_timeout) begin
                seen = 1'b1;
                chk("to_id", bus.out_id, 5);
                chk("to_range", (bus.out_ts >= TO && bus.out_ts <= TO + DEPTH), 1);
            end
        end
        chk("to_seen", seen, 1);
        drive(1'b0, 0, 1'b1, 5, 1'b1);
        chk("to_end_blocked", bus.inflight, 0);

        // Counter wrap.
        idle_until_cnt(250);
        drive(1'b1, 1, 1'b0, 0, 1'b1);
        idle_until_cnt(4);
        drive(1'b0, 0, 1'b1, 1, 1'b1);
        chk("wrap_ts", bus.out_ts, 10);
        chk("wrap_start", bus.out_start_ts, 250);

        // End for id 7 in the cycle the sweeper reaches it stale.
        drive(1'b1, 7, 1'b0, 0, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 80 && !seen; k++) begin
            if (m_sp == 7 && m_vld[7] && age(7) >= TO) begin
                seen = 1'b1;
                drive(1'b0, 0, 1'b1, 7, 1'b1);
                chk("collide_id", bus.out_id, 7);
                chk("collide_to", bus.out_timeout, 0);
            end else begin
                idle(1'b1);
            end
        end
        chk("collide_seen", seen, 1);
        idle(1'b1);
        chk("collide_single", bus.out_valid, 0);

        // Backpressure with a full FIFO.
        for (int i = 0; i < 5; i++) drive(1'b1, i, 1'b0, 0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, 0, 1'b1, i, 1'b0);
        chk("bp_full", bus.out_count, OD);
        chk("bp_id4_open", m_vld[4], 1);
        drive(1'b0, 0, 1'b1, 4, 1'b0);
        chk("bp_head_stable", bus.out_id, 0);
        for (int k = 0; k < 10 && m_vld[4]; k++) drive(1'b0, 0, 1'b1, 4, 1'b1);
        chk("bp_id4_closed", m_vld[4], 0);
        for (int k = 0; k < 8; k++) idle(1'b1);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            drive(bit'($urandom_range(0, 1)), $urandom_range(0, DEPTH-1),
                  bit'($urandom_range(0, 3) != 0), $urandom_range(0, DEPTH-1),
                  bit'($urandom_range(0, 3) != 0));
        end

        // Reset mid-operation.
        do_reset();
        for (int i = 8; i < 13; i++) drive(1'b1, i, 1'b0, 0, 1'b0);
        drive(1'b0, 0, 1'b1, 11, 1'b0);
        drive(1'b0, 0, 1'b1, 12, 1'b0);
        chk("pre_rst_count", bus.out_count, 2);
        chk("pre_rst_inflight", bus.inflight, 3);
        do_reset();
        drive(1'b1, 8, 1'b0, 0, 1'b1);
        chk("post_rst_inflight", bus.inflight, 1);
        for (int k = 0; k < 3; k++) idle(1'b1);
        drive(1'b0, 0, 1'b1, 8, 1'b1);
        chk("post_rst_start_ts", bus.out_start_ts, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/event_timestamper_mc.md
Name: event_timestamper_mc

Overview:
- Successor to the single-slot event timestamper.
- Tracks up to 2**ID_W concurrent in-flight events by ID and emits {id, start_ts, end_ts, delta} records.
- Records go through an OUT_DEPTH-entry output FIFO instead of a single hold register.
- Adds same-cycle close/reopen of one ID, a background timeout sweeper that retires stale IDs as flagged records, and occupancy outputs for monitoring. Sits between packet-event sources (RX/TX taps) and the record writer.

Parameters:
- ID_W, 4, event ID width; scoreboard depth DEPTH = 2**ID_W.
- TS_W, 64, timestamp counter width.
- OUT_DEPTH, 4, output FIFO entries; power of two, >= 2.
- TIMEOUT, 0, age in cycles at which an in-flight ID is force-retired; 0 disables the sweeper.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_valid  in  1  start request
- start_ready  out  1  start accepted when high with start_valid
- start_id  in  ID_W  ID to open
- end_valid  in  1  end request
- end_ready  out  1  end accepted when high with end_valid
- end_id  in  ID_W  ID to close
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer pops head
- out_id  out  ID_W  head record ID
- out_start_ts  out  TS_W  start timestamp
- out_end_ts  out  TS_W  end or timeout timestamp
- out_ts  out  TS_W  out_end_ts - out_start_ts, modulo 2**TS_W
- out_timeout  out  1  1 = record produced by sweeper, 0 = normal end
- inflight  out  ID_W+1  number of open IDs
- out_count  out  $clog2(OUT_DEPTH)+1  FIFO occupancy

Behaviour:
- Counter: cnt is free-running, reset 0, +1 per cycle, wraps modulo 2**TS_W. All deltas are unsigned modulo subtraction, so wrap yields the correct delta.
- Scoreboard: per-ID valid bit and start_ts. Reset clears all valid bits; start_ts contents are don't-care.
- FIFO write port: single write port. fifo_room = (out_count < OUT_DEPTH) || (out_valid && out_ready).
- end_ready = valid[end_id] && fifo_room.
- end_fire = end_valid && end_ready. On end_fire:
  - push {end_id, start_ts[end_id], cnt, cnt - start_ts[end_id], timeout=0};
  - clear valid[end_id].
- start_ready = !valid[start_id] || (end_fire && end_id == start_id). Same-cycle close+reopen is allowed.
- start_fire: valid[start_id] <= 1, start_ts[start_id] <= cnt.
  - Start write takes precedence over end clear on the same ID.
  - The closing record uses the old start_ts.
- Ready signals are combinational from state and the same-cycle valids. end_ready never depends on start_valid.
- Latency: record pushed on the end_fire edge; out_valid = 1 the next cycle. With an empty FIFO and out_ready held high, one record retires per cycle.
- FIFO:
  - First-word fall-through from registers; head fields held stable while out_valid && !out_ready.
  - Simultaneous push and pop at full is legal; count unchanged.
  - Full with no pop drops end_ready to 0; no record is ever lost.
- Sweeper (TIMEOUT > 0):
  - sweep_ptr (ID_W bits, reset 0) examines one ID per cycle.
  - stale = valid[sweep_ptr] && (cnt - start_ts[sweep_ptr]) >= TIMEOUT.
  - Retire when stale && !end_fire && fifo_room: push {sweep_ptr, start_ts, cnt, delta, timeout=1}, clear valid, advance pointer.
  - Stale but blocked (end_fire, or no fifo_room): pointer holds.
  - Not stale: pointer advances, modulo DEPTH.
  - End has priority over the sweeper for the FIFO write port.
  - A start to the swept ID cannot collide, because start_ready is 0 while valid.
- TIMEOUT == 0: sweeper logic absent; out_timeout is always 0.
- inflight:
  - +1 per start_fire, -1 per end_fire, -1 per sweep retire.
  - Same-ID close+reopen nets 0.
  - Saturation is impossible by construction (max DEPTH).
- Reset mid-operation:
  - Next cycle all of the following are 0: outputs, counter, FIFO contents/occupancy, valid bits, sweep_ptr, inflight, out_count.
  - Pending records are discarded.
- end for a closed ID: end_ready = 0, and the request stalls until the ID opens.
- start for an open ID (no same-cycle close): start_ready = 0.

Test Plan:
- Basic: start id 3 at cnt=10, end id 3 at cnt=25 → one cycle later out_valid=1, out_id=3, out_start_ts=10, out_end_ts=25, out_ts=15, out_timeout=0; inflight 1→0.
- Wrap: TS_W=8, start id 1 at cnt=250, end at cnt=4 (next lap) → out_ts=10.
- Same-cycle close/reopen: id 5 open from cnt=20; at cnt=40 end_valid and start_valid both for id 5 → both ready. Record start 20 / end 40 / ts 20; new start_ts=40; inflight unchanged.
- Backpressure: OUT_DEPTH=4, out_ready=0, open and then close ids 0-4 → first 4 ends accepted, end_ready=0 for id 4, out_count=4. Raise out_ready → records pop in order 0,1,2,3, then id 4 accepted; head fields stable while stalled.
- Timeout: TIMEOUT=32, start id 2 at cnt=100, no end → record with out_id=2, out_timeout=1, out_ts ≥ 32 and ≤ 32+DEPTH. valid cleared, so a later end for id 2 sees end_ready=0. Also issue end_fire for id 7 in the same cycle the sweeper targets stale id 7 → a single normal record, timeout=0.
- Reset mid-operation: 3 IDs open and 2 records queued, pulse rst → next cycle out_valid=0, inflight=0, out_count=0, cnt=0; a subsequent start on a previously open ID is accepted.
